sh7604_mac_fetch: RTL
=====================

Name: sh7604_mac_fetch

Overview:
- Operand-fetch sequencer directly upstream of the SH7604 multiply/accumulate unit.
- For MAC.L/MAC.W @Rm+,@Rn+ it issues two memory reads, delivers each operand over the MULT write port (MA first, then MB), and returns post-incremented Rn/Rm for writeback.
- Also forwards CLRMAC.
- Stalls on MULT busy, memory wait and address error.

Parameters:
- none

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable; every state change is qualified by it
- EN  in  1  core enable; when low, hold all state and registers
- RES_N  in  1  soft reset; low returns the FSM to IDLE (synchronous, on CE_R)
- CMD_VALID  in  1  decoder presents a MAC/CLRMAC command
- CMD_OP  in  4  1001 MAC.L, 1011 MAC.W, 1111 CLRMAC; other codes are ignored
- CMD_S  in  1  SR.S saturation flag, latched with the command
- RN_IDX, RM_IDX  in  4 each  register indices
- RN_VAL, RM_VAL  in  32 each  register contents
- CMD_READY  out  1  high only in IDLE
- MEM_REQ  out  1  read request, held until acknowledged
- MEM_A  out  32  read address
- MEM_LONG  out  1  1 = longword access, 0 = word access
- MEM_ACK  in  1  one-cycle pulse; MEM_DI is valid in the same cycle
- MEM_DI  in  32  aligned 32-bit bus word
- MAC_SEL  out  2  01 = load MA, 10 = load MB and start, 11 = CLRMAC
- MAC_OP  out  4  latched CMD_OP
- MAC_S  out  1  latched CMD_S
- MAC_WE  out  1  write strobe to MULT
- MAC_A  out  32  address of the delivered operand (MULT uses bit 1 for word-lane select)
- MAC_DO  out  32  delivered bus word
- MAC_BUSY  in  1  MULT busy flag
- RN_WE, RM_WE  out  1 each  writeback strobes
- RN_NEW, RM_NEW  out  32 each  incremented register values
- ADDR_ERR  out  1  one-cycle pulse on misaligned operand address

Behaviour:
- Reset value of all outputs is 0, except CMD_READY = 1. FSM resets to IDLE.
- States: IDLE, WAITM, RD1, DLV1, RD2, DLV2, WB, CLR.
- IDLE, when CMD_VALID accepted:
  - Latch the command; set SZ = 4 (MAC.L) or 2 (MAC.W).
  - CLRMAC goes to WAITM with the CLR flag set.
  - MAC.L/MAC.W go to WAITM.
  - Any other op is ignored and the FSM stays in IDLE.
- WAITM:
  - Hold while MAC_BUSY = 1. MA must not be overwritten while the previous product is still in flight.
  - When MAC_BUSY = 0, go to CLR or RD1.
- CLR: MAC_WE = 1, MAC_SEL = 11 for one CE_R cycle, then IDLE.
- Address check (at RD1 and RD2 entry):
  - MAC.L: A[1:0] must be 00. MAC.W: A[0] must be 0.
  - On violation: ADDR_ERR pulses, no MEM_REQ, no writeback, no MAC_WE, FSM goes to IDLE.
- RD1:
  - MEM_A = RN_VAL, MEM_REQ = 1, MEM_LONG = (SZ == 4).
  - On MEM_ACK: capture MEM_DI and go to DLV1.
- DLV1:
  - One cycle with MAC_WE = 1, MAC_SEL = 01, MAC_A = the RD1 address.
  - Next state RD2.
- RD2 address:
  - Normally RM_VAL.
  - If RM_IDX == RN_IDX, use RN_VAL + SZ.
- DLV2: one cycle with MAC_SEL = 10, then WB.
- WB:
  - Normal case: RN_WE and RM_WE pulse together; RN_NEW = RN_VAL + SZ, RM_NEW = RM_VAL + SZ.
  - If RM_IDX == RN_IDX: only RN_WE pulses, with RN_NEW = RN_VAL + 2*SZ.
  - Then IDLE.
- Arithmetic: 32-bit adds wrap modulo 2^32 (0xFFFFFFFC + 4 = 0).
- Pulses: MAC_WE, RN_WE, RM_WE and ADDR_ERR each last exactly one CE_R-qualified cycle.
- MEM_REQ protocol: MEM_A and MEM_LONG are stable while MEM_REQ is high. A MEM_ACK arriving while not requesting is ignored.
- Latency with zero memory wait and MULT idle: 7 CE_R cycles from accept to return to IDLE.
- EN low:
  - Freeze in the current state.
  - Strobes are deasserted; MEM_REQ is held.
- Soft or hard reset mid-operation:
  - Immediate return to IDLE; pending MEM_REQ is dropped.
  - No partial writeback. Registers are untouched even if MA was already loaded.

Decomposition:
- Add MAC op encodings (MACL = 1001, MACW = 1011, CLRMAC = 1111) and the MAC_SEL codes to SH7604_PKG as localparams.
- Add the FSM state enum (typedef) to SH7604_PKG.
- No sub-module; alignment check and incrementers are inline.

Test Plan:
- MAC.L, Rn = 0x1000, Rm = 0x2000, zero wait:
  - MEM_A = 0x1000, then 0x2000.
  - MAC_SEL = 01, then 10.
  - RN_NEW = 0x1004, RM_NEW = 0x2004.
  - Back in IDLE after 7 CE_R cycles.
- MAC.W with Rn = Rm = R3 = 0x0402:
  - Reads at 0x0402, then 0x0404, with MEM_LONG = 0.
  - MAC_A[1] = 1, then 0.
  - Only RN_WE, with RN_NEW = 0x0406.
- MAC_BUSY held high for 3 cycles after accept:
  - No MEM_REQ until MAC_BUSY falls.
  - Then the normal sequence runs.
- MAC.L with Rm = 0x2002:
  - First operand delivered (MAC_SEL = 01).
  - ADDR_ERR pulses; no RD2 request, no WB strobes, FSM returns to IDLE.
- CLRMAC while MULT is idle: a single cycle with MAC_SEL = 11, MAC_WE = 1, MAC_OP = 1111; no MEM_REQ.
- RES_N low during RD2 with MEM_ACK withheld:
  - MEM_REQ drops and CMD_READY = 1 on the next cycle.
  - No writeback.
  - Also check address wrap: Rn = 0xFFFFFFFC gives RN_NEW = 0.

Source files
------------

// File: rtl/sh7604_mac_fetch_pkg.sv
// Shared encodings for the SH7604 MAC operand-fetch sequencer.
package sh7604_mac_fetch_pkg;

   localparam logic [3:0] OP_MACL   = 4'b1001;
   localparam logic [3:0] OP_MACW   = 4'b1011;
   localparam logic [3:0] OP_CLRMAC = 4'b1111;

   localparam logic [1:0] SEL_MA  = 2'b01;
   localparam logic [1:0] SEL_MB  = 2'b10;
   localparam logic [1:0] SEL_CLR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAITM,
      S_RD1,
      S_DLV1,
      S_RD2,
      S_DLV2,
      S_WB,
      S_CLR
   } mac_state_e;

   function automatic logic [31:0] op_size(input logic long_acc);
      return long_acc ? 32'd4 : 32'd2;
   endfunction

   function automatic logic addr_ok(input logic [31:0] a, input logic long_acc);
      return long_acc ? (a[1:0] == 2'b00) : (a[0] == 1'b0);
   endfunction

endpackage

// File: rtl/sh7604_mac_fetch.sv
// Operand fetch for MAC.L/MAC.W @Rm+,@Rn+ and CLRMAC forwarding to the MULT unit.
module sh7604_mac_fetch
   import sh7604_mac_fetch_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        EN,
   input  logic        RES_N,
   input  logic        CMD_VALID,
   input  logic [3:0]  CMD_OP,
   input  logic        CMD_S,
   input  logic [3:0]  RN_IDX,
   input  logic [3:0]  RM_IDX,
   input  logic [31:0] RN_VAL,
   input  logic [31:0] RM_VAL,
   output logic        CMD_READY,
   output logic        MEM_REQ,
   output logic [31:0] MEM_A,
   output logic        MEM_LONG,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_DI,
   output logic [1:0]  MAC_SEL,
   output logic [3:0]  MAC_OP,
   output logic        MAC_S,
   output logic        MAC_WE,
   output logic [31:0] MAC_A,
   output logic [31:0] MAC_DO,
   input  logic        MAC_BUSY,
   output logic        RN_WE,
   output logic        RM_WE,
   output logic [31:0] RN_NEW,
   output logic [31:0] RM_NEW,
   output logic        ADDR_ERR
);

   mac_state_e  state;
   logic        clr_q;
   logic        long_q;
   logic [3:0]  rn_idx_q;
   logic [3:0]  rm_idx_q;
   logic [31:0] rn_q;
   logic [31:0] rm_q;
   logic        mac_we_q;
   logic        rn_we_q;
   logic        rm_we_q;
   logic        addr_err_q;

   logic [31:0] sz;
   logic [31:0] rd2_addr;
   logic        same_reg;
   logic        cmd_ok;

   always_comb begin
      sz       = op_size(long_q);
      same_reg = (rn_idx_q == rm_idx_q);
      rd2_addr = same_reg ? (rn_q + sz) : rm_q;
      cmd_ok   = CMD_VALID &&
                 ((CMD_OP == OP_MACL) || (CMD_OP == OP_MACW) || (CMD_OP == OP_CLRMAC));
   end

   assign CMD_READY = (state == S_IDLE);

   // Strobe registers hold across EN-low cycles; gating here keeps them off while frozen.
   assign MAC_WE   = mac_we_q   & EN;
   assign RN_WE    = rn_we_q    & EN;
   assign RM_WE    = rm_we_q    & EN;
   assign ADDR_ERR = addr_err_q & EN;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_IDLE;
         clr_q      <= 1'b0;
         long_q     <= 1'b0;
         rn_idx_q   <= '0;
         rm_idx_q   <= '0;
         rn_q       <= '0;
         rm_q       <= '0;
         mac_we_q   <= 1'b0;
         rn_we_q    <= 1'b0;
         rm_we_q    <= 1'b0;
         addr_err_q <= 1'b0;
         MEM_REQ    <= 1'b0;
         MEM_A      <= '0;
         MEM_LONG   <= 1'b0;
         MAC_SEL    <= '0;
         MAC_OP     <= '0;
         MAC_S      <= 1'b0;
         MAC_A      <= '0;
         MAC_DO     <= '0;
         RN_NEW     <= '0;
         RM_NEW     <= '0;
      end else if (CE_R) begin
         if (!RES_N) begin
            state      <= S_IDLE;
            MEM_REQ    <= 1'b0;
            mac_we_q   <= 1'b0;
            rn_we_q    <= 1'b0;
            rm_we_q    <= 1'b0;
            addr_err_q <= 1'b0;
         end else if (EN) begin
            mac_we_q   <= 1'b0;
            rn_we_q    <= 1'b0;
            rm_we_q    <= 1'b0;
            addr_err_q <= 1'b0;
            case (state)
               S_IDLE: begin
                  if (cmd_ok) begin
                     MAC_OP   <= CMD_OP;
                     MAC_S    <= CMD_S;
                     clr_q    <= (CMD_OP == OP_CLRMAC);
                     long_q   <= (CMD_OP == OP_MACL);
                     rn_idx_q <= RN_IDX;
                     rm_idx_q <= RM_IDX;
                     rn_q     <= RN_VAL;
                     rm_q     <= RM_VAL;
                     state    <= S_WAITM;
                  end
               end
               S_WAITM: begin
                  if (!MAC_BUSY) begin
                     if (clr_q) begin
                        mac_we_q <= 1'b1;
                        MAC_SEL  <= SEL_CLR;
                        state    <= S_CLR;
                     end else if (addr_ok(rn_q, long_q)) begin
                        MEM_A    <= rn_q;
                        MEM_LONG <= long_q;
                        MEM_REQ  <= 1'b1;
                        state    <= S_RD1;
                     end else begin
                        addr_err_q <= 1'b1;
                        state      <= S_IDLE;
                     end
                  end
               end
               S_RD1: begin
                  if (MEM_REQ && MEM_ACK) begin
                     MEM_REQ  <= 1'b0;
                     mac_we_q <= 1'b1;
                     MAC_SEL  <= SEL_MA;
                     MAC_A    <= MEM_A;
                     MAC_DO   <= MEM_DI;
                     state    <= S_DLV1;
                  end
               end
               S_DLV1: begin
                  if (addr_ok(rd2_addr, long_q)) begin
                     MEM_A   <= rd2_addr;
                     MEM_REQ <= 1'b1;
                     state   <= S_RD2;
                  end else begin
                     addr_err_q <= 1'b1;
                     state      <= S_IDLE;
                  end
               end
               S_RD2: begin
                  if (MEM_REQ && MEM_ACK) begin
                     MEM_REQ  <= 1'b0;
                     mac_we_q <= 1'b1;
                     MAC_SEL  <= SEL_MB;
                     MAC_A    <= MEM_A;
                     MAC_DO   <= MEM_DI;
                     state    <= S_DLV2;
                  end
               end
               S_DLV2: begin
                  // @Rn+ and @Rm+ on the same register advance it twice
                  rn_we_q <= 1'b1;
                  if (same_reg) begin
                     RN_NEW <= rn_q + (sz << 1);
                  end else begin
                     RN_NEW  <= rn_q + sz;
                     RM_NEW  <= rm_q + sz;
                     rm_we_q <= 1'b1;
                  end
                  state <= S_WB;
               end
               S_WB:    state <= S_IDLE;
               S_CLR:   state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
